pwm_multich: RTL
================

Name: pwm_multich

Overview:
- Multi-channel PWM generator with a runtime-programmable prescaler.
- Produces CH outputs that share one period counter. Each output has its own duty value.
- Supports edge-aligned and center-aligned modes. Period and duty are double-buffered and take effect only at period boundaries.
- Runs on the 50 MHz board clock. The prescaler generates a one-cycle tick enable, so no derived clock is used.

Parameters:
- CH, 4, number of PWM channels (≥1).
- CNT_W, 8, width of the period/duty counter.
- PRESC_W, 16, width of the prescaler reload value.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  run control; 0 halts and clears the counters.
- mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled with the shadow load.
- presc  input  PRESC_W  prescaler reload; tick period = presc+1 clk cycles.
- period  input  CNT_W  top count of the main counter.
- duty  input  CH*CNT_W  per-channel duty; channel i is bits [i*CNT_W +: CNT_W].
- load  input  1  one-cycle strobe requesting a shadow update.
- pwm  output  CH  PWM outputs, registered.
- tick  output  1  one-cycle pulse on each prescaler expiry.
- period_end  output  1  one-cycle pulse on the tick where a period completes.
- load_pending  output  1  high while a requested load awaits its boundary.

Behaviour:
- Reset (async): clears the prescaler counter, main counter, direction (up), active period/duty/mode, pending flag, pwm, tick and period_end. All outputs are 0.
- Prescaler:
  - pcnt counts 0..presc while enable=1.
  - tick=1 in the cycle where pcnt==presc; pcnt then returns to 0.
  - presc=0 gives tick every cycle.
  - presc is read live, not shadowed. If presc is lowered below the current pcnt, the next cycle wraps pcnt to 0 and asserts tick.
- Main counter (advances only on tick):
  - Edge mode: cnt goes 0,1..P,0,... (P = active period). The period is P+1 ticks. period_end is asserted on the tick where cnt goes P→0.
  - Center mode: cnt goes 0,1..P,P-1..1,0,... The period is 2P ticks. dir flips at P and at 0. period_end is asserted on the tick where cnt goes 1→0.
  - If P==0 in center mode, the block behaves as edge mode with P=0.
- Output:
  - pwm[i] is registered as enable & (cnt < D_i). It is updated every clk, one cycle after cnt.
  - D_i=0 gives constant 0.
  - Edge mode: D_i>P gives constant 1. Center mode: the output is high for 2·min(D_i,P) ticks; D_i>P gives constant 1.
- Shadow load:
  - A load strobe sets load_pending. A strobe while already pending is absorbed, and the latest inputs win.
  - At the next period boundary (the same tick that asserts period_end), period/duty/mode are copied to the active registers and load_pending clears.
  - If load coincides with the boundary tick, the update happens at that boundary.
  - When enable=0, load copies immediately (next edge) and load_pending stays 0.
  - A mode change resets cnt to 0 and dir to up.
- Disable:
  - enable=0 clears pcnt and cnt, sets dir up, clears tick and period_end, and drives pwm to 0 on the next edge.
  - Active registers are retained.
  - Re-enable starts from cnt=0.
- Reset mid-period: all outputs go to 0 immediately, without waiting for a clock.

Test Plan:
- rst, then enable=1, presc=0, period=9, duty ch0=3 ch1=0 ch2=10 ch3=5, load, edge mode:
  - ch0 high 3 of every 10 clk, ch1 always 0, ch2 always 1, ch3 high 5/10.
  - period_end every 10 clk.
- presc=4, period=3, duty0=2, edge:
  - tick every 5 clk.
  - pwm0 high 10 clk out of 20.
- Center mode, presc=0, period=4, duty0=2:
  - cnt 0,1,2,3,4,3,2,1.
  - pwm0 high 4 of 8 clk, centered on cnt=0.
  - period_end every 8 clk.
- Running edge period=9, apply load with duty0=7 mid-period:
  - load_pending=1 until the boundary.
  - The current period keeps 3 high cycles; the next period has 7.
- Assert rst for 1 cycle mid-high phase:
  - pwm drops asynchronously and all outputs read 0.
  - After release, pwm stays 0 until the next load.
- Drop enable mid-period, then reassert:
  - pwm is 0 on the next edge.
  - The counter restarts at 0 with the unchanged active duty.

Source files
------------

// File: rtl/pwm_multich.sv
// Multi-channel PWM sharing one period counter, with a prescaler tick enable
// and double-buffered period/duty/mode that switch at period boundaries.
module pwm_multich #(
  parameter int unsigned CH      = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PRESC_W-1:0]    presc,
  input  logic [CNT_W-1:0]      period,
  input  logic [CH*CNT_W-1:0]   duty,
  input  logic                  load,
  output logic [CH-1:0]         pwm,
  output logic                  tick,
  output logic                  period_end,
  output logic                  load_pending
);

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

  logic [PRESC_W-1:0]  pcnt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [0:0]          dir, dir_nxt;
  logic [CNT_W-1:0]    per_a, per_s;
  logic [CH*CNT_W-1:0] duty_a, duty_s;
  logic                mode_a, mode_s;
  logic                center, boundary;
  logic [CH-1:0]       pwm_nxt;

  // Center mode: dir turns down on reaching P, so the top count belongs to the
  // falling slope. Rising compares cnt<D, falling cnt<=D: exactly 2*min(D,P)
  // high ticks centred on cnt=0.
  always_comb begin
    center   = mode_a && (per_a != '0);
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (center) begin
      if (dir == DIR_UP) begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt >= per_a) dir_nxt = DIR_DN;
      end else begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) begin
          dir_nxt  = DIR_UP;
          boundary = 1'b1;
        end
      end
    end else begin
      dir_nxt = DIR_UP;
      if (cnt >= per_a) begin
        cnt_nxt  = '0;
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pwm_nxt = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (center && dir == DIR_DN)
        pwm_nxt[i] = (cnt <= duty_a[i*CNT_W +: CNT_W]);
      else
        pwm_nxt[i] = (cnt < duty_a[i*CNT_W +: CNT_W]);
    end
  end

  // A boundary always yields cnt=0/dir=up, which also covers the reset of
  // the counter required when the loaded mode differs from the active one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt         <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      per_a        <= '0;
      duty_a       <= '0;
      mode_a       <= 1'b0;
      per_s        <= '0;
      duty_s       <= '0;
      mode_s       <= 1'b0;
      load_pending <= 1'b0;
      pwm          <= '0;
      tick         <= 1'b0;
      period_end   <= 1'b0;
    end else if (!enable) begin
      pcnt         <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      tick         <= 1'b0;
      period_end   <= 1'b0;
      pwm          <= '0;
      load_pending <= 1'b0;
      if (load) begin
        per_a  <= period;
        duty_a <= duty;
        mode_a <= mode;
        per_s  <= period;
        duty_s <= duty;
        mode_s <= mode;
      end
    end else begin
      tick       <= (pcnt >= presc);
      pcnt       <= (pcnt >= presc) ? '0 : pcnt + 1'b1;
      pwm        <= pwm_nxt;
      period_end <= tick && boundary;
      if (tick) begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
      if (load) begin
        per_s  <= period;
        duty_s <= duty;
        mode_s <= mode;
      end
      if (tick && boundary && (load_pending || load)) begin
        per_a        <= load ? period : per_s;
        duty_a       <= load ? duty   : duty_s;
        mode_a       <= load ? mode   : mode_s;
        load_pending <= 1'b0;
      end else if (load) begin
        load_pending <= 1'b1;
      end
    end
  end

endmodule
